dnn_argmax_collector: RTL and testbench

//  Downstream stage of the CNN+DNN top: captures each output-layer score vector (out_valid/out_data/out_done),

---
 rtl/dnn_out_pkg.sv | 15 +
 rtl/dnn_result_fifo.sv | 48 ++++
 rtl/dnn_argmax_collector.sv | 157 +++++++++++++++
 tb/tb_dnn_argmax_collector.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_out_pkg.sv
// Shared types and helpers for the DNN output-layer argmax collector.
package dnn_out_pkg;

  localparam int ScoreW = 32;

  typedef logic signed [ScoreW-1:0] score_t;

  typedef enum logic [1:0] {IDLE, SCAN, RESULT} argmax_state_e;

  // Index width that never collapses to zero bits for a single-class layer.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dnn_result_fifo.sv
// Synchronous score-beat FIFO in front of the argmax engine; storage is not reset.
module dnn_result_fifo import dnn_out_pkg::*; #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);

endmodule

// File: rtl/dnn_argmax_collector.sv
// Buffers output-layer score beats and returns the winning class via valid/ready.
// Define ARGMAX_MARGIN_EN to add result_margin (best minus runner-up score).
module dnn_argmax_collector import dnn_out_pkg::*; #(
  parameter int BitSize    = 32,
  parameter int NumClasses = 2,
  parameter int FifoDepth  = 4
) (
  input  logic                                 clk,
  input  logic                                 res_n,
  input  logic                                 in_valid,
  input  logic [NumClasses-1:0][BitSize-1:0]   in_data,
  input  logic                                 in_done,
  input  logic                                 result_ready,
  output logic                                 result_valid,
  output logic [clog2_min1(NumClasses)-1:0]    result_class,
  output logic [BitSize-1:0]                   result_score,
  output logic                                 result_last,
`ifdef ARGMAX_MARGIN_EN
  output logic [BitSize-1:0]                   result_margin,
`endif
  output logic                                 overflow,
  output logic                                 busy
);

  localparam int IdxW  = clog2_min1(NumClasses);
  localparam int WordW = NumClasses * BitSize + 1;

  logic [WordW-1:0]              fifo_wdata;
  logic [WordW-1:0]              fifo_rdata;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FifoDepth):0]    fifo_count;

  argmax_state_e                 state;
  logic                          done_pend;
  logic                          tag;
  logic [NumClasses-1:0][BitSize-1:0] work_p0;
  logic [IdxW-1:0]               lane_p0;
  logic signed [BitSize-1:0]     lane_score;
  logic signed [BitSize-1:0]     best_p1;
  logic [IdxW-1:0]               idx_p1;
  logic                          last_p1;
  logic                          vld_p1;
`ifdef ARGMAX_MARGIN_EN
  logic signed [BitSize-1:0]     second_p1;
`endif

  assign tag        = in_done | done_pend;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign fifo_push  = in_valid && (!fifo_full || fifo_pop);
  assign fifo_wdata = {tag, in_data};

  dnn_result_fifo #(
    .Width (WordW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .res_n (res_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage p0: popped beat held in the work register while lanes are scanned.
  always_ff @(posedge clk) begin
    if (fifo_pop) work_p0 <= fifo_rdata[WordW-2:0];
  end

  assign lane_score = work_p0[lane_p0];

  // Stage p1: running best/index, result handshake and input bookkeeping.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      lane_p0   <= '0;
      best_p1   <= '0;
      idx_p1    <= '0;
      last_p1   <= 1'b0;
      vld_p1    <= 1'b0;
      done_pend <= 1'b0;
      overflow  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_p1 <= '0;
`endif
    end else begin
      if (in_valid) begin
        done_pend <= fifo_push ? 1'b0 : tag;
        if (!fifo_push) overflow <= 1'b1;
      end else if (in_done) begin
        done_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fifo_pop) begin
            best_p1 <= fifo_rdata[BitSize-1:0];
            idx_p1  <= '0;
            lane_p0 <= IdxW'(1);
            last_p1 <= fifo_rdata[WordW-1];
`ifdef ARGMAX_MARGIN_EN
            second_p1 <= {1'b1, {(BitSize-1){1'b0}}};
`endif
            if (NumClasses == 1) begin
              state  <= RESULT;
              vld_p1 <= 1'b1;
            end else begin
              state  <= SCAN;
            end
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (lane_score > best_p1) begin
            best_p1 <= lane_score;
            idx_p1  <= lane_p0;
`ifdef ARGMAX_MARGIN_EN
            second_p1 <= best_p1;
          end else if (lane_score > second_p1) begin
            second_p1 <= lane_score;
`endif
          end
          if (lane_p0 == IdxW'(NumClasses - 1)) begin
            state  <= RESULT;
            vld_p1 <= 1'b1;
          end else begin
            lane_p0 <= lane_p0 + IdxW'(1);
          end
        end
        RESULT: begin
          if (result_ready) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result_valid = vld_p1;
  assign result_class = idx_p1;
  assign result_score = best_p1;
  assign result_last  = last_p1;
  assign busy         = (fifo_count != '0) || (state != IDLE);

`ifdef ARGMAX_MARGIN_EN
  // Low BitSize bits of the BitSize+1 difference equal a plain BitSize subtraction.
  assign result_margin = (NumClasses == 1) ? '0 : (best_p1 - second_p1);
`endif

endmodule

// File: tb/tb_dnn_argmax_collector.sv
// Directed self-checking bench for dnn_argmax_collector (4 classes, 32-bit scores, depth 4).
module tb_dnn_argmax_collector;

  logic               clk = 1'b0;
  logic               res_n;
  logic               in_valid;
  logic [3:0][31:0]   in_data;
  logic               in_done;
  logic               result_ready;
  logic               result_valid;
  logic [1:0]         result_class;
  logic [31:0]        result_score;
  logic               result_last;
`ifdef ARGMAX_MARGIN_EN
  logic [31:0]        result_margin;
`endif
  logic               overflow;
  logic               busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dnn_argmax_collector #(
    .BitSize    (32),
    .NumClasses (4),
    .FifoDepth  (4)
  ) dut (
    .clk          (clk),
    .res_n        (res_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_done      (in_done),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .result_class (result_class),
    .result_score (result_score),
    .result_last  (result_last),
`ifdef ARGMAX_MARGIN_EN
    .result_margin(result_margin),
`endif
    .overflow     (overflow),
    .busy         (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic signed [31:0] l3, input logic signed [31:0] l2,
                            input logic signed [31:0] l1, input logic signed [31:0] l0,
                            input logic done);
    in_valid = 1'b1;
    in_data  = {l3, l2, l1, l0};
    in_done  = done;
    step();
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic wait_result(input int max_cycles, output bit ok);
    int n = 0;
    while (!result_valid && n < max_cycles) begin
      step();
      n++;
    end
    ok = result_valid;
  endtask

  task automatic apply_reset();
    res_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_done      = 1'b0;
    result_ready = 1'b0;
    repeat (3) step();
    res_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (result_valid !== 1'b0 || result_last !== 1'b0) $display("FAIL reset_valid_last got %b%b exp 00", result_valid, result_last);
    else passed++;
    total++;
    if (result_class !== 2'd0 || result_score !== 32'd0) $display("FAIL reset_class_score got %0d/%0d exp 0/0", result_class, result_score);
    else passed++;
    total++;
    if (overflow !== 1'b0 || busy !== 1'b0) $display("FAIL reset_ovf_busy got %b%b exp 00", overflow, busy);
    else passed++;
  endtask

  task automatic test_tie();
    result_ready = 1'b1;
    drive_beat(-5, 7, 7, 2, 1'b0);
    repeat (3) step();
    total++;
    if (result_valid !== 1'b0) $display("FAIL tie_early_valid got %b exp 0 at cycle 4", result_valid);
    else passed++;
    step();
    total++;
    if (result_valid !== 1'b1) $display("FAIL tie_latency got valid=%b exp 1 at cycle 5", result_valid);
    else passed++;
    total++;
    if (result_class !== 2'd1 || result_score !== 32'd7 || result_last !== 1'b0)
      $display("FAIL tie_result got class=%0d score=%0d last=%b exp 1/7/0", result_class, $signed(result_score), result_last);
    else passed++;
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (result_margin !== 32'd0) $display("FAIL tie_margin got %0d exp 0", result_margin);
    else passed++;
`endif
    step();
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0) $display("FAIL tie_handshake got valid=%b busy=%b exp 0/0", result_valid, busy);
    else passed++;
  endtask

  task automatic test_negative();
    bit ok;
    result_ready = 1'b1;
    drive_beat(-1, -9, -3, -2, 1'b0);
    wait_result(20, ok);
    total++;
    if (!ok || result_class !== 2'd3 || result_score !== 32'hFFFF_FFFF)
      $display("FAIL neg_result got valid=%b class=%0d score=%0d exp 1/3/-1", ok, result_class, $signed(result_score));
    else passed++;
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (result_margin !== 32'd1) $display("FAIL neg_margin got %0d exp 1", result_margin);
    else passed++;
`endif
    step();
  endtask

  task automatic test_overflow();
    bit ok;
    logic signed [31:0] l [4];
    result_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) l[k] = (k == i % 4) ? 32'(10 + i) : 32'sd0;
      drive_beat(l[3], l[2], l[1], l[0], 1'b0);
      if (i == 4) begin
        total++;
        if (overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0 after 5 beats", overflow);
        else passed++;
      end
      if (i == 5) begin
        total++;
        if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1 after 6 beats", overflow);
        else passed++;
      end
    end
    result_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      wait_result(20, ok);
      total++;
      if (!ok || result_class !== 2'(r % 4) || result_score !== 32'(10 + r))
        $display("FAIL ovf_drain%0d got valid=%b class=%0d score=%0d exp 1/%0d/%0d",
                 r, ok, result_class, result_score, r % 4, 10 + r);
      else passed++;
      step();
    end
    wait_result(20, ok);
    total++;
    if (ok !== 1'b0) $display("FAIL ovf_dropped got extra result class=%0d score=%0d exp none", result_class, result_score);
    else passed++;
    total++;
    if (overflow !== 1'b1 || busy !== 1'b0) $display("FAIL ovf_sticky got ovf=%b busy=%b exp 1/0", overflow, busy);
    else passed++;
  endtask

  task automatic test_last();
    bit ok;
    logic exp_last [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    result_ready = 1'b1;
    drive_beat(0, 0, 0, 3, 1'b0);
    drive_beat(0, 0, 4, 0, 1'b0);
    drive_beat(0, 5, 0, 0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      if (r == 3) begin
        in_done = 1'b1;
        step();
        in_done = 1'b0;
        step();
        drive_beat(6, 0, 0, 0, 1'b0);
      end
      if (r == 4) drive_beat(0, 0, 0, 8, 1'b0);
      wait_result(30, ok);
      total++;
      if (!ok || result_last !== exp_last[r])
        $display("FAIL last%0d got valid=%b last=%b exp 1/%b", r, ok, result_last, exp_last[r]);
      else passed++;
      step();
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit stable = 1'b1;
    result_ready = 1'b0;
    drive_beat(0, 100, 0, 0, 1'b0);
    wait_result(20, ok);
    total++;
    if (!ok || result_class !== 2'd2 || result_score !== 32'd100)
      $display("FAIL stall_first got valid=%b class=%0d score=%0d exp 1/2/100", ok, result_class, result_score);
    else passed++;
    drive_beat(0, 0, 50, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (result_valid !== 1'b1 || result_class !== 2'd2 || result_score !== 32'd100 || busy !== 1'b1) begin
        if (stable) $display("FAIL stall_hold cycle %0d got valid=%b class=%0d score=%0d busy=%b exp 1/2/100/1",
                             c, result_valid, result_class, result_score, busy);
        stable = 1'b0;
      end
    end
    total++;
    if (stable) passed++;
    result_ready = 1'b1;
    step();
    wait_result(20, ok);
    total++;
    if (!ok || result_class !== 2'd1 || result_score !== 32'd50)
      $display("FAIL stall_second got valid=%b class=%0d score=%0d exp 1/1/50", ok, result_class, result_score);
    else passed++;
    step();
  endtask

  task automatic test_reset_midscan();
    bit ok;
    result_ready = 1'b0;
    drive_beat(1, 2, 3, 5, 1'b0);
    drive_beat(0, 9, 0, 0, 1'b0);
    drive_beat(0, 0, 9, 0, 1'b0);
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b1 || result_score !== 32'd5)
      $display("FAIL rst_pre got valid=%b busy=%b score=%0d exp 0/1/5", result_valid, busy, result_score);
    else passed++;
    #2 res_n = 1'b0;
    #1;
    total++;
    if (result_valid !== 1'b0 || result_class !== 2'd0 || result_score !== 32'd0 ||
        result_last !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_async got valid=%b class=%0d score=%0d last=%b ovf=%b busy=%b exp all 0",
               result_valid, result_class, result_score, result_last, overflow, busy);
    else passed++;
    step();
    @(negedge clk);
    res_n = 1'b1;
    result_ready = 1'b1;
    wait_result(30, ok);
    total++;
    if (ok !== 1'b0 || busy !== 1'b0) $display("FAIL rst_flush got valid=%b busy=%b exp 0/0", ok, busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_negative();
    test_overflow();
    test_last();
    test_stall();
    test_reset_midscan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion (%0d/%0d)", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
